down_counter: RTL and testbench
===============================

# down_counter

Registered down counter driven by the same single-bit count input `x` as the existing up counter. It is the decrementing side of that counter pair: reset loads the top value and each qualified `x` cycle steps the count toward zero. A borrow pulse and a sticky underflow flag let a downstream block chain counters or detect an exhausted count. The block also supports a parallel load and a choice of wrap or saturate behaviour at zero.

## Interface
- `WIDTH`, default 2, width of the count (`state`); must be ≥ 1.
- `WRAP`, default 1; 1 = wrap from 0 to all-ones, 0 = saturate at 0.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-low; sampled only on the rising edge of `clk`.
- `x` input 1: count enable; 1 = decrement this cycle, 0 = hold.
- `load` input 1: parallel load strobe.
- `load_val` input WIDTH: value written to `state` when `load`=1.
- `state` output WIDTH: registered count.
- `zero` output 1: combinational, 1 when `state` == 0.
- `borrow` output 1: registered one-cycle pulse on underflow attempt.
- `underflow` output 1: registered sticky flag, set on first underflow attempt.

## Operation
- Priority per rising edge: `rst`=0 > `load`=1 > `x`=1 > hold.
- Reset (`rst`=0 at edge): `state` = all-ones (2'b11 at default), `borrow` = 0, `underflow` = 0; `zero` follows as 0. `x` and `load` are ignored that cycle.
- Load: `state` = `load_val`, `borrow` = 0, `underflow` cleared to 0. `x` is ignored that cycle; no decrement occurs.
- Decrement (`x`=1, no load, `state` ≠ 0): `state` = `state` − 1 (modulo 2^WIDTH never needed); `borrow` = 0.
- Underflow attempt (`x`=1, no load, `state` = 0):
  - `WRAP`=1: `state` = all-ones.
  - `WRAP`=0: `state` stays 0.
  - Both modes: `borrow` = 1 for exactly that following cycle; `underflow` set to 1.
- Hold (`x`=0, no load): `state` unchanged; `borrow` = 0; `underflow` unchanged.
- `underflow` clears only on reset or load; a plain decrement never clears it.
- `x` held high for multiple cycles decrements once per cycle, with no edge detection.
- Arithmetic is unsigned WIDTH bits. `load_val` is taken verbatim, including all-ones and 0.

## Timing
- Latency: one cycle. The `state`, `borrow` and `underflow` values caused by inputs at edge N are visible after edge N.
- `zero` is combinational from registered `state`, so it has zero added latency relative to `state`.
- `borrow` is high for one cycle per underflow attempt. Consecutive attempts (e.g. `WRAP`=0, `x` held at 1 on zero) pulse `borrow` every cycle.
- Reset asserted mid-count takes effect at the next edge regardless of `x`/`load`. Between edges, outputs keep their previous values, because reset is synchronous.
- Load and underflow in the same cycle: load wins; `borrow` = 0 and `underflow` = 0.
- Deasserting reset: the first edge with `rst`=1 may already decrement (`x`=1 takes `state` from 2'b11 to 2'b10).

## Test plan
- Reset then count: hold `rst`=0 for 5 edges, then `rst`=1 with `x`=1 for 3 edges → `state` 3, 2, 1, 0. `zero`=1 after the 3rd edge; `borrow`=0 and `underflow`=0 throughout.
- Wrap (`WRAP`=1, WIDTH=2): from `state`=0 apply `x`=1 for one edge → `state`=3, `borrow`=1 for one cycle, `underflow`=1 and it stays 1 through later decrements 3→2→1.
- Saturate (`WRAP`=0): from `state`=0 hold `x`=1 for 3 edges → `state` stays 0, `borrow`=1 on each of the 3 cycles, `underflow`=1.
- Toggled enable: alternate `x` 1/0 every 5 clocks starting from reset value 3 → `state` decrements only while `x`=1, one step per edge. Each 5-clock high phase drops by 5 mod 4 in wrap mode, and holds steady during `x`=0.
- Load priority: with `underflow`=1 and `state`=0, apply `load`=1, `load_val`=2, `x`=1 on the same edge → `state`=2, `borrow`=0, `underflow`=0. Next edge with `x`=1 → `state`=1.
- Reset mid-count: at `state`=1 with `x`=1, drive `rst`=0 for one edge → `state`=3, `borrow`=0, `underflow`=0. The following edge with `rst`=1, `x`=1 → `state`=2.

Source files
------------

// File: rtl/down_counter.sv
// down_counter: registered down counter with parallel load, wrap/saturate
// at zero, a one-cycle borrow pulse and a sticky underflow flag.
module down_counter #(
  parameter int unsigned WIDTH = 2,
  parameter bit          WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] state,
  output logic             zero,
  output logic             borrow,
  output logic             underflow
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] state_next;
  logic             borrow_next;
  logic             underflow_next;

  // Next-state selection in priority order: load, then count, else hold.
  always_comb begin
    state_next     = state;
    borrow_next    = 1'b0;
    underflow_next = underflow;
    if (load) begin
      state_next     = load_val;
      underflow_next = 1'b0;
    end else if (x) begin
      if (state == '0) begin
        state_next     = WRAP ? '1 : '0;
        borrow_next    = 1'b1;
        underflow_next = 1'b1;
      end else begin
        state_next = state - ONE;
      end
    end
  end

  // Register update; synchronous active-low reset loads the top value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= '1;
      borrow    <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= state_next;
      borrow    <= borrow_next;
      underflow <= underflow_next;
    end
  end

  assign zero = (state == '0);

endmodule

// File: tb/tb_down_counter.sv
// Scoreboard bench for down_counter: one wrapping and one saturating
// instance, directed vectors with hand-computed expectations.
module tb_down_counter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // wrapping instance signals
  logic       rst_w = 1'b0, x_w = 1'b0, load_w = 1'b0;
  logic [1:0] lv_w = '0;
  logic [1:0] state_w;
  logic       zero_w, borrow_w, uf_w;

  // saturating instance signals
  logic       rst_s = 1'b0, x_s = 1'b0, load_s = 1'b0;
  logic [1:0] lv_s = '0;
  logic [1:0] state_s;
  logic       zero_s, borrow_s, uf_s;

  down_counter #(.WIDTH(2), .WRAP(1'b1)) u_wrap (
    .clk(clk), .rst(rst_w), .x(x_w), .load(load_w), .load_val(lv_w),
    .state(state_w), .zero(zero_w), .borrow(borrow_w), .underflow(uf_w)
  );

  down_counter #(.WIDTH(2), .WRAP(1'b0)) u_sat (
    .clk(clk), .rst(rst_s), .x(x_s), .load(load_s), .load_val(lv_s),
    .state(state_s), .zero(zero_s), .borrow(borrow_s), .underflow(uf_s)
  );

  typedef struct {
    bit         sel;     // 0 = wrapping instance, 1 = saturating instance
    logic [1:0] st;
    logic       zr;
    logic       br;
    logic       uf;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  // Apply one vector to the selected instance (other one idles), clock it,
  // then queue the expected post-edge outputs.
  task automatic step(input bit sel, input logic r, input logic xi,
                      input logic ld, input logic [1:0] lv,
                      input logic [1:0] st, input logic br, input logic uf,
                      input string name);
    exp_t e;
    if (sel == 1'b0) begin
      rst_w = r; x_w = xi; load_w = ld; lv_w = lv;
      rst_s = 1'b1; x_s = 1'b0; load_s = 1'b0;
    end else begin
      rst_s = r; x_s = xi; load_s = ld; lv_s = lv;
      rst_w = 1'b1; x_w = 1'b0; load_w = 1'b0;
    end
    @(posedge clk);
    #1;
    e.sel = sel; e.st = st; e.zr = (st == 2'd0); e.br = br; e.uf = uf;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are valid every cycle; check on the falling edge.
  initial begin
    exp_t e;
    logic [4:0] act, req;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.sel == 1'b0) act = {state_w, zero_w, borrow_w, uf_w};
        else               act = {state_s, zero_s, borrow_s, uf_s};
        req = {e.st, e.zr, e.br, e.uf};
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got state/zero/borrow/uf=%b required %b",
                      e.name, act, req);
      end
    end
  end

  initial begin
    // Reset then count (wrap instance)
    repeat (5) step(0, 0, 1, 0, 2'd0, 2'd3, 0, 0, "reset_hold");
    step(0, 1, 1, 0, 2'd0, 2'd2, 0, 0, "count_1");
    step(0, 1, 1, 0, 2'd0, 2'd1, 0, 0, "count_2");
    step(0, 1, 1, 0, 2'd0, 2'd0, 0, 0, "count_3_zero");
    // Wrap from zero, underflow sticky through decrements
    step(0, 1, 1, 0, 2'd0, 2'd3, 1, 1, "wrap_borrow");
    step(0, 1, 1, 0, 2'd0, 2'd2, 0, 1, "wrap_sticky_2");
    step(0, 1, 1, 0, 2'd0, 2'd1, 0, 1, "wrap_sticky_1");
    step(0, 1, 1, 0, 2'd0, 2'd0, 0, 1, "wrap_sticky_0");
    // Load beats decrement/underflow and clears the flag
    step(0, 1, 1, 1, 2'd2, 2'd2, 0, 0, "load_priority");
    step(0, 1, 1, 0, 2'd0, 2'd1, 0, 0, "after_load");
    // Reset mid-count
    step(0, 0, 1, 0, 2'd0, 2'd3, 0, 0, "mid_reset");
    step(0, 1, 1, 0, 2'd0, 2'd2, 0, 0, "post_reset_dec");
    // Toggled enable from reset value
    step(0, 0, 0, 0, 2'd0, 2'd3, 0, 0, "tog_reset");
    step(0, 1, 1, 0, 2'd0, 2'd2, 0, 0, "tog_hi_a1");
    step(0, 1, 1, 0, 2'd0, 2'd1, 0, 0, "tog_hi_a2");
    step(0, 1, 1, 0, 2'd0, 2'd0, 0, 0, "tog_hi_a3");
    step(0, 1, 1, 0, 2'd0, 2'd3, 1, 1, "tog_hi_a4");
    step(0, 1, 1, 0, 2'd0, 2'd2, 0, 1, "tog_hi_a5");
    repeat (5) step(0, 1, 0, 0, 2'd0, 2'd2, 0, 1, "tog_lo_a");
    step(0, 1, 1, 0, 2'd0, 2'd1, 0, 1, "tog_hi_b1");
    step(0, 1, 1, 0, 2'd0, 2'd0, 0, 1, "tog_hi_b2");
    step(0, 1, 1, 0, 2'd0, 2'd3, 1, 1, "tog_hi_b3");
    step(0, 1, 1, 0, 2'd0, 2'd2, 0, 1, "tog_hi_b4");
    step(0, 1, 1, 0, 2'd0, 2'd1, 0, 1, "tog_hi_b5");
    repeat (3) step(0, 1, 0, 0, 2'd0, 2'd1, 0, 1, "tog_lo_b");
    // Load verbatim boundary values
    step(0, 1, 0, 1, 2'd3, 2'd3, 0, 0, "load_ones");
    step(0, 1, 0, 1, 2'd0, 2'd0, 0, 0, "load_zero");
    step(0, 1, 0, 0, 2'd0, 2'd0, 0, 0, "hold_zero");

    // Saturating instance
    repeat (2) step(1, 0, 1, 1, 2'd1, 2'd3, 0, 0, "sat_reset");
    step(1, 1, 1, 0, 2'd0, 2'd2, 0, 0, "sat_dec_2");
    step(1, 1, 1, 0, 2'd0, 2'd1, 0, 0, "sat_dec_1");
    step(1, 1, 1, 0, 2'd0, 2'd0, 0, 0, "sat_dec_0");
    repeat (3) step(1, 1, 1, 0, 2'd0, 2'd0, 1, 1, "sat_hold_borrow");
    step(1, 1, 0, 0, 2'd0, 2'd0, 0, 1, "sat_idle");
    step(1, 1, 0, 1, 2'd1, 2'd1, 0, 0, "sat_load1");
    step(1, 1, 1, 0, 2'd0, 2'd0, 0, 0, "sat_dec_to0");
    step(1, 1, 1, 0, 2'd0, 2'd0, 1, 1, "sat_underflow");
    step(1, 1, 1, 1, 2'd2, 2'd2, 0, 0, "sat_load_wins");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL drain: %0d entries left unchecked, required 0",
               exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
